ftdi_sync_tx: RTL

- Write-side master for the FT232H-style 245 synchronous FIFO interface, clocked by the FTDI 60 MHz clock.
- Buffers bytes from fabric (status/telemetry/readback) in a small FIFO and writes them to the host using ftdi_wr_n/ftdi_txe_n.
- Shares the bidirectional ftdi_data bus with the existing receive path through a req/gnt handshake; the top-level arbiter gives the reader priority whenever ftdi_rxf_n is low.

---
 rtl/ftdi_pkg.sv | 16 +
 rtl/ftdi_sync_fifo.sv | 55 +++++
 rtl/ftdi_sync_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT232H 245-synchronous FIFO write and read paths.
package ftdi_pkg;

  localparam int FTDI_DATA_W = 8;

  // Cycles with data driven and no strobe between taking the bus and writing.
  localparam int TURNAROUND_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    TURN,
    WRITE
  } tx_state_e;

endpackage

// File: rtl/ftdi_sync_fifo.sv
// Single-clock FIFO with a combinational head and an occupancy output.
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ftdi_sync_tx.sv
// Write-side master for the FTDI 245 synchronous FIFO: buffers fabric bytes,
// arbitrates for the shared data bus and issues SIWU after an idle period.
module ftdi_sync_tx
  import ftdi_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int FLUSH_IDLE = 64,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                   clk_60,
  input  logic                   rst_n,
  input  logic [FTDI_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [LW-1:0]          tx_level,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  input  logic                   ftdi_txe_n,
  output logic                   ftdi_wr_n,
  output logic                   ftdi_siwu_n,
  output logic [FTDI_DATA_W-1:0] ftdi_data_out,
  output logic                   ftdi_data_oe
);

  tx_state_e state_q, state_d;
  logic      wr_n_q, wr_n_d;
  logic      oe_q, oe_d;
  logic      req_q, req_d;
  logic      fifo_full, fifo_empty;
  logic      push, accepted;

  assign push     = tx_valid && !fifo_full;
  assign accepted = (state_q == WRITE) && !wr_n_q && !ftdi_txe_n;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FTDI_DATA_W)
  ) u_fifo (
    .clk_i   (clk_60),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (tx_data),
    .pop_i   (accepted),
    .rdata_o (ftdi_data_out),
    .level_o (tx_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_ready     = !fifo_full;
  assign bus_req      = req_q;
  assign ftdi_wr_n    = wr_n_q;
  assign ftdi_data_oe = oe_q;

  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
    end
  end

  // A grant lost during turnaround releases the bus before any strobe is issued.
  always_comb begin
    state_d = state_q;
    wr_n_d  = wr_n_q;
    oe_d    = oe_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !ftdi_txe_n) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = TURN;
          oe_d    = 1'b1;
        end else if (fifo_empty) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      TURN: begin
        if (!bus_gnt) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          req_d   = 1'b0;
        end else begin
          state_d = WRITE;
          wr_n_d  = 1'b0;
        end
      end
      WRITE: begin
        if (!bus_gnt || (accepted && (tx_level == LW'(1)) && !push)) begin
          state_d = IDLE;
          wr_n_d  = 1'b1;
          oe_d    = 1'b0;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        wr_n_d  = 1'b1;
        oe_d    = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  if (FLUSH_IDLE > 0) begin : gen_flush
    localparam int            CW        = $clog2(FLUSH_IDLE + 1);
    localparam logic [CW-1:0] FIRE_CNT  = CW'(FLUSH_IDLE - 1);

    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic          siwu_n_q;
    logic          idle_empty;

    assign idle_empty  = (state_q == IDLE) && fifo_empty;
    assign ftdi_siwu_n = siwu_n_q;

    // Armed by each accepted byte; fires once, or is abandoned when new data arrives.
    always_ff @(posedge clk_60 or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        armed_q  <= 1'b0;
        siwu_n_q <= 1'b1;
      end else begin
        siwu_n_q <= 1'b1;
        if (accepted) begin
          cnt_q   <= '0;
          armed_q <= 1'b1;
        end else if (armed_q && push) begin
          armed_q <= 1'b0;
        end else if (armed_q && idle_empty) begin
          if (cnt_q == FIRE_CNT) begin
            armed_q  <= 1'b0;
            siwu_n_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end else begin : gen_no_flush
    assign ftdi_siwu_n = 1'b1;
  end

endmodule
